// File: rtl/sgpu_icb_arb_pkg.sv
// Shared types and constants for the SGPU two-requester ICB arbiter.
// Requester IDs and the round-robin pick helper live here.
package sgpu_icb_arb_pkg;

    localparam int SGPU_ARB_IDW = 1;

    typedef logic [SGPU_ARB_IDW-1:0] arb_id_t;

    localparam arb_id_t REQ_M0 = 1'b0;
    localparam arb_id_t REQ_M1 = 1'b1;

    // Unlocked pick: on contention favour the requester not granted last, unless fixed priority.
    function automatic arb_id_t arb_pick(
        input logic    vld0,
        input logic    vld1,
        input arb_id_t last,
        input logic    fixed_prio
    );
        arb_id_t pick;
        if (vld0 && vld1) begin
            pick = fixed_prio ? REQ_M0 : ~last;
        end else if (vld1) begin
            pick = REQ_M1;
        end else begin
            pick = REQ_M0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/sgpu_icb_arb_if.sv
// One ICB link (command + response channels). The master modport issues
// commands and accepts responses; the slave modport is the opposite side.
interface sgpu_icb_arb_if #(
    parameter int AW = 32,
    parameter int DW = 64
);

    logic            cmd_vld;
    logic            cmd_rdy;
    logic            cmd_read;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_wmask;
    logic            rsp_vld;
    logic            rsp_rdy;
    logic            rsp_err;
    logic [DW-1:0]   rsp_rdata;

    modport master (
        output cmd_vld, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_rdy,
        input  cmd_rdy, rsp_vld, rsp_err, rsp_rdata
    );

    modport slave (
        input  cmd_vld, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_rdy,
        output cmd_rdy, rsp_vld, rsp_err, rsp_rdata
    );

endinterface

// File: rtl/sgpu_arb_id_fifo.sv
// Synchronous FIFO holding the requester ID of each outstanding command.
// Push is ignored when full, pop is ignored when empty.
module sgpu_arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(DEPTH - 1)) begin
            n = '0;
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    assign full_o    = (cnt_q == CNT_W'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;
    assign dout_o    = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/sgpu_icb_arb.sv
// Two-requester ICB arbiter sharing the SGPU memory-side port.
// Define SGPU_ICB_ARB_FIXED_PRIO_EN for fixed priority to requester 0; default is round-robin.
module sgpu_icb_arb
    import sgpu_icb_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 64,
    parameter int OUTS_NUM = 2
) (
    input  logic            clk,
    input  logic            rst,
    sgpu_icb_arb_if.slave   m0_icb,
    sgpu_icb_arb_if.slave   m1_icb,
    sgpu_icb_arb_if.master  s_icb,
    output logic            orphan_rsp_err
);

`ifdef SGPU_ICB_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    arb_id_t         last_q, last_d;
    logic            locked_q, locked_d;
    arb_id_t         lock_id_q, lock_id_d;
    logic            orphan_q, orphan_d;

    arb_id_t         sel_s;
    arb_id_t         head_id_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            cmd_vld_s;
    logic            cmd_hs_s;
    logic            cmd_read_s;
    logic [AW-1:0]   cmd_addr_s;
    logic [DW-1:0]   cmd_wdata_s;
    logic [DW/8-1:0] cmd_wmask_s;
    logic            m0_rsp_vld_s;
    logic            m1_rsp_vld_s;
    logic            rsp_rdy_s;
    logic            rsp_pop_s;

    // A held selection keeps the presented command stable until it is accepted.
    assign sel_s = locked_q ? lock_id_q
                            : arb_pick(m0_icb.cmd_vld, m1_icb.cmd_vld, last_q, FIXED_PRIO);

    assign cmd_vld_s = (m0_icb.cmd_vld | m1_icb.cmd_vld) & ~fifo_full_s;
    assign cmd_hs_s  = cmd_vld_s & s_icb.cmd_rdy;

    // Command field passthrough from the selected requester.
    always_comb begin
        cmd_read_s  = m0_icb.cmd_read;
        cmd_addr_s  = m0_icb.cmd_addr;
        cmd_wdata_s = m0_icb.cmd_wdata;
        cmd_wmask_s = m0_icb.cmd_wmask;
        case (sel_s)
            REQ_M1: begin
                cmd_read_s  = m1_icb.cmd_read;
                cmd_addr_s  = m1_icb.cmd_addr;
                cmd_wdata_s = m1_icb.cmd_wdata;
                cmd_wmask_s = m1_icb.cmd_wmask;
            end
            default: begin
                cmd_read_s  = m0_icb.cmd_read;
                cmd_addr_s  = m0_icb.cmd_addr;
                cmd_wdata_s = m0_icb.cmd_wdata;
                cmd_wmask_s = m0_icb.cmd_wmask;
            end
        endcase
    end

    assign s_icb.cmd_vld   = cmd_vld_s;
    assign s_icb.cmd_read  = cmd_read_s;
    assign s_icb.cmd_addr  = cmd_addr_s;
    assign s_icb.cmd_wdata = cmd_wdata_s;
    assign s_icb.cmd_wmask = cmd_wmask_s;
    assign m0_icb.cmd_rdy  = (sel_s == REQ_M0) & s_icb.cmd_rdy & ~fifo_full_s;
    assign m1_icb.cmd_rdy  = (sel_s == REQ_M1) & s_icb.cmd_rdy & ~fifo_full_s;

    // Response steering by FIFO head; with nothing outstanding the beat is swallowed.
    always_comb begin
        m0_rsp_vld_s = 1'b0;
        m1_rsp_vld_s = 1'b0;
        rsp_rdy_s    = 1'b0;
        if (fifo_empty_s) begin
            rsp_rdy_s = s_icb.rsp_vld;
        end else begin
            case (head_id_s)
                REQ_M0: begin
                    m0_rsp_vld_s = s_icb.rsp_vld;
                    rsp_rdy_s    = m0_icb.rsp_rdy;
                end
                REQ_M1: begin
                    m1_rsp_vld_s = s_icb.rsp_vld;
                    rsp_rdy_s    = m1_icb.rsp_rdy;
                end
                default: begin
                    rsp_rdy_s = 1'b0;
                end
            endcase
        end
    end

    assign rsp_pop_s        = s_icb.rsp_vld & rsp_rdy_s & ~fifo_empty_s;
    assign s_icb.rsp_rdy    = rsp_rdy_s;
    assign m0_icb.rsp_vld   = m0_rsp_vld_s;
    assign m0_icb.rsp_err   = m0_rsp_vld_s & s_icb.rsp_err;
    assign m0_icb.rsp_rdata = m0_rsp_vld_s ? s_icb.rsp_rdata : '0;
    assign m1_icb.rsp_vld   = m1_rsp_vld_s;
    assign m1_icb.rsp_err   = m1_rsp_vld_s & s_icb.rsp_err;
    assign m1_icb.rsp_rdata = m1_rsp_vld_s ? s_icb.rsp_rdata : '0;
    assign orphan_rsp_err   = orphan_q;

    // Grant history, lock and orphan next-state.
    always_comb begin
        last_d    = last_q;
        locked_d  = locked_q;
        lock_id_d = lock_id_q;
        if (cmd_hs_s) begin
            locked_d = 1'b0;
            last_d   = sel_s;
        end else if (cmd_vld_s) begin
            locked_d  = 1'b1;
            lock_id_d = sel_s;
        end else begin
            locked_d = locked_q;
        end
        orphan_d = orphan_q | (s_icb.rsp_vld & fifo_empty_s);
    end

    // Arbiter state registers; last resets to 1 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= REQ_M1;
            locked_q  <= 1'b0;
            lock_id_q <= REQ_M0;
            orphan_q  <= 1'b0;
        end else begin
            last_q    <= last_d;
            locked_q  <= locked_d;
            lock_id_q <= lock_id_d;
            orphan_q  <= orphan_d;
        end
    end

    sgpu_arb_id_fifo #(
        .DEPTH (OUTS_NUM),
        .WIDTH (SGPU_ARB_IDW)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_hs_s),
        .din_i   (sel_s),
        .pop_i   (rsp_pop_s),
        .dout_o  (head_id_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

endmodule

// File: tb/tb_sgpu_icb_arb.sv
// Directed, table-driven bench for sgpu_icb_arb plus hand sequences for
// lock, response routing and reset-with-outstanding corner cases.
module tb_sgpu_icb_arb;

`ifdef SGPU_ICB_ARB_FIXED_PRIO_EN
    localparam bit F = 1'b1;
`else
    localparam bit F = 1'b0;
`endif

    localparam logic [63:0] A0 = 64'h0000_0000_8000_0000;
    localparam logic [63:0] A1 = 64'h0000_0000_9000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic orphan_rsp_err;

    sgpu_icb_arb_if #(.AW(32), .DW(64)) m0_icb ();
    sgpu_icb_arb_if #(.AW(32), .DW(64)) m1_icb ();
    sgpu_icb_arb_if #(.AW(32), .DW(64)) s_icb ();

    sgpu_icb_arb #(.AW(32), .DW(64), .OUTS_NUM(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .m0_icb         (m0_icb),
        .m1_icb         (m1_icb),
        .s_icb          (s_icb),
        .orphan_rsp_err (orphan_rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          do_rst;
        bit          m0v, m1v, srdy, rspv, rerr;
        logic [63:0] rdata;
        bit          e_svld, e_sel, e_crdy0, e_crdy1, e_rv0, e_rv1, e_srr, e_orph;
    } vec_t;

    vec_t tbl[$];
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    function automatic vec_t mk(bit rs, bit m0v, bit m1v, bit srdy, bit rspv, bit rerr,
                                logic [63:0] rd, bit svld, bit sel, bit c0, bit c1,
                                bit rv0, bit rv1, bit srr, bit orph);
        vec_t v;
        v.do_rst = rs;   v.m0v = m0v;   v.m1v = m1v;   v.srdy = srdy;
        v.rspv = rspv;   v.rerr = rerr; v.rdata = rd;
        v.e_svld = svld; v.e_sel = sel; v.e_crdy0 = c0; v.e_crdy1 = c1;
        v.e_rv0 = rv0;   v.e_rv1 = rv1; v.e_srr = srr;  v.e_orph = orph;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {63'h0, act}, {63'h0, exp});
    endtask

    task automatic set_in(input bit m0v, input bit m1v, input bit srdy,
                          input bit rspv, input bit rerr, input logic [63:0] rd);
        m0_icb.cmd_vld    = m0v;
        m1_icb.cmd_vld    = m1v;
        s_icb.cmd_rdy     = srdy;
        s_icb.rsp_vld     = rspv;
        s_icb.rsp_err     = rerr;
        s_icb.rsp_rdata   = rd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive(input bit m0v, input bit m1v, input bit srdy,
                         input bit rspv, input bit rerr, input logic [63:0] rd);
        @(negedge clk);
        set_in(m0v, m1v, srdy, rspv, rerr, rd);
        #1;
    endtask

    task automatic run_row(input int idx, input vec_t r);
        logic [63:0] ea;
        if (r.do_rst) do_reset();
        else @(negedge clk);
        set_in(r.m0v, r.m1v, r.srdy, r.rspv, r.rerr, r.rdata);
        #1;
        ea = r.e_sel ? A1 : A0;
        chk1($sformatf("row%0d s_cmd_vld", idx), s_icb.cmd_vld, r.e_svld);
        chk($sformatf("row%0d s_cmd_addr", idx), {32'h0, s_icb.cmd_addr}, ea);
        chk1($sformatf("row%0d m0_cmd_rdy", idx), m0_icb.cmd_rdy, r.e_crdy0);
        chk1($sformatf("row%0d m1_cmd_rdy", idx), m1_icb.cmd_rdy, r.e_crdy1);
        chk1($sformatf("row%0d m0_rsp_vld", idx), m0_icb.rsp_vld, r.e_rv0);
        chk1($sformatf("row%0d m1_rsp_vld", idx), m1_icb.rsp_vld, r.e_rv1);
        chk1($sformatf("row%0d s_rsp_rdy", idx), s_icb.rsp_rdy, r.e_srr);
        chk1($sformatf("row%0d orphan", idx), orphan_rsp_err, r.e_orph);
        if (r.e_rv0) chk($sformatf("row%0d m0_rdata", idx), m0_icb.rsp_rdata, r.rdata);
        if (r.e_rv1) chk($sformatf("row%0d m1_rdata", idx), m1_icb.rsp_rdata, r.rdata);
    endtask

    initial begin
        m0_icb.cmd_read  = 1'b1;
        m0_icb.cmd_addr  = A0[31:0];
        m0_icb.cmd_wdata = 64'h0;
        m0_icb.cmd_wmask = 8'hFF;
        m0_icb.rsp_rdy   = 1'b1;
        m1_icb.cmd_read  = 1'b0;
        m1_icb.cmd_addr  = A1[31:0];
        m1_icb.cmd_wdata = 64'hCAFE;
        m1_icb.cmd_wmask = 8'h0F;
        m1_icb.rsp_rdy   = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk1("rst s_cmd_vld", s_icb.cmd_vld, 1'b0);
        chk1("rst m0_cmd_rdy", m0_icb.cmd_rdy, 1'b0);
        chk1("rst m0_rsp_vld", m0_icb.rsp_vld, 1'b0);
        chk1("rst s_rsp_rdy", s_icb.rsp_rdy, 1'b0);
        chk1("rst orphan", orphan_rsp_err, 1'b0);
        rst = 1'b0;

        // single requester read
        tbl.push_back(mk(1,1,0,1,0,0,64'h0,                  1,0,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,1,0,64'h1122_3344_5566_7788,0,0,1,0,1,0,1,0));
        // fairness: both valid, one response retired per grant
        tbl.push_back(mk(1,1,1,1,0,0,64'h0,   1,0, 1, 0, 0, 0,1'b0,0));
        tbl.push_back(mk(0,1,1,1,1,0,64'h101, 1,!F,F,!F, 1, 0, 1,0));
        tbl.push_back(mk(0,1,1,1,1,0,64'h202, 1,0, 1, 0, F,!F, 1,0));
        tbl.push_back(mk(0,1,1,1,1,0,64'h303, 1,!F,F,!F, 1, 0, 1,0));
        tbl.push_back(mk(0,1,1,1,1,0,64'h404, 1,0, 1, 0, F,!F, 1,0));
        tbl.push_back(mk(0,1,1,1,1,0,64'h505, 1,!F,F,!F, 1, 0, 1,0));
        tbl.push_back(mk(0,0,0,1,1,0,64'h606, 0,0, 1, 0, F,!F, 1,0));
        // outstanding limit: full blocks even when a pop happens that cycle
        tbl.push_back(mk(1,1,0,1,0,0,64'h0,  1,0,1,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,1,0,0,64'h0,  1,0,1,0,0,0,1,0));
        tbl.push_back(mk(0,1,0,1,0,0,64'h0,  0,0,0,0,0,0,1,0));
        tbl.push_back(mk(0,1,0,1,1,0,64'hA1, 0,0,0,0,1,0,1,0));
        tbl.push_back(mk(0,1,0,1,0,0,64'h0,  1,0,1,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,1,1,0,64'hA2, 0,0,0,0,1,0,1,0));
        tbl.push_back(mk(0,0,0,1,1,0,64'hA3, 0,0,1,0,1,0,1,0));
        // orphan response is swallowed and sticks until reset
        tbl.push_back(mk(0,0,0,1,1,0,64'hBAD,0,0,1,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,1,0,0,64'h0,  0,0,1,0,0,0,0,1));
        tbl.push_back(mk(0,1,0,1,0,0,64'h0,  1,0,1,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,64'h0,  0,0,0,0,0,0,0,0));

        foreach (tbl[i]) run_row(i, tbl[i]);

        // lock: m0 stalled, m1 joins; selection must not move until the handshake
        do_reset();
        drive(1, 0, 1, 0, 0, 64'h0);
        chk1("pre s_cmd_vld", s_icb.cmd_vld, 1'b1);
        m0_icb.rsp_rdy = 1'b0;
        drive(0, 0, 1, 1, 0, 64'h77);
        chk1("rsp_rdy follows m0", s_icb.rsp_rdy, 1'b0);
        chk1("rsp held m0_rsp_vld", m0_icb.rsp_vld, 1'b1);
        m0_icb.rsp_rdy = 1'b1;
        drive(0, 0, 1, 1, 0, 64'h77);
        chk1("rsp_rdy released", s_icb.rsp_rdy, 1'b1);
        drive(1, 0, 0, 0, 0, 64'h0);
        chk("lock c1 addr", {32'h0, s_icb.cmd_addr}, A0);
        drive(1, 1, 0, 0, 0, 64'h0);
        chk("lock c2 addr", {32'h0, s_icb.cmd_addr}, A0);
        chk1("lock c2 m1_cmd_rdy", m1_icb.cmd_rdy, 1'b0);
        drive(1, 1, 0, 0, 0, 64'h0);
        chk("lock c3 addr", {32'h0, s_icb.cmd_addr}, A0);
        drive(1, 1, 1, 0, 0, 64'h0);
        chk("lock hs addr", {32'h0, s_icb.cmd_addr}, A0);
        chk1("lock hs m0_cmd_rdy", m0_icb.cmd_rdy, 1'b1);
        drive(0, 1, 1, 0, 0, 64'h0);
        chk("after lock addr", {32'h0, s_icb.cmd_addr}, A1);
        chk1("after lock m1_cmd_rdy", m1_icb.cmd_rdy, 1'b1);
        drive(0, 0, 1, 1, 0, 64'h10);
        chk1("lock drain m0_rsp_vld", m0_icb.rsp_vld, 1'b1);
        drive(0, 0, 1, 1, 0, 64'h20);
        chk1("lock drain m1_rsp_vld", m1_icb.rsp_vld, 1'b1);

        // response routing with error: m1 write, then m0 read
        do_reset();
        drive(0, 1, 1, 0, 0, 64'h0);
        chk1("route c0 read", s_icb.cmd_read, 1'b0);
        chk("route c0 addr", {32'h0, s_icb.cmd_addr}, A1);
        drive(1, 0, 1, 0, 0, 64'h0);
        chk1("route c1 read", s_icb.cmd_read, 1'b1);
        drive(0, 0, 1, 1, 1, 64'h0);
        chk1("route m1_rsp_vld", m1_icb.rsp_vld, 1'b1);
        chk1("route m1_rsp_err", m1_icb.rsp_err, 1'b1);
        chk1("route m0 quiet", m0_icb.rsp_vld, 1'b0);
        drive(0, 0, 1, 1, 0, 64'hDEAD);
        chk1("route m0_rsp_vld", m0_icb.rsp_vld, 1'b1);
        chk("route m0_rdata", m0_icb.rsp_rdata, 64'hDEAD);
        chk1("route m0_rsp_err", m0_icb.rsp_err, 1'b0);
        chk1("route m1 quiet", m1_icb.rsp_vld, 1'b0);
        drive(0, 0, 0, 0, 0, 64'h0);
        chk1("route orphan", orphan_rsp_err, 1'b0);

        // reset with a command outstanding: its response becomes an orphan
        drive(1, 0, 1, 0, 0, 64'h0);
        do_reset();
        drive(0, 0, 0, 1, 0, 64'h55);
        chk1("mid-rst m0_rsp_vld", m0_icb.rsp_vld, 1'b0);
        chk1("mid-rst s_rsp_rdy", s_icb.rsp_rdy, 1'b1);
        drive(1, 1, 1, 0, 0, 64'h0);
        chk1("mid-rst orphan", orphan_rsp_err, 1'b1);
        chk("mid-rst first grant", {32'h0, s_icb.cmd_addr}, A0);
        drive(1, 1, 1, 0, 0, 64'h0);
        chk("mid-rst second grant", {32'h0, s_icb.cmd_addr}, F ? A0 : A1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
